// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - data SRAM responder: word RAM plus LED/NUM/SWITCH/TIMER peripheral registers, 1-cycle read.
// Optional free-running TIMER at offset 16'he000 enabled by macro SRAM_RESP_TIMER_EN.
module data_sram_resp #(
    parameter int          RAM_AW    = 10,
    parameter logic [15:0] PERIPH_HI = 16'h1faf
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led,
    output logic [31:0] num_data
);

    localparam logic [15:0] OFF_LED    = 16'hf000;
    localparam logic [15:0] OFF_NUM    = 16'hf010;
    localparam logic [15:0] OFF_SWITCH = 16'hf020;
    localparam logic [15:0] OFF_TIMER  = 16'he000;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return res;
    endfunction

    logic [31:0]       r_ram [0:(2**RAM_AW)-1];
    logic [31:0]       r_rdata;
    logic [15:0]       r_led;
    logic [31:0]       r_num;
    logic [7:0]        r_sw_meta;
    logic [7:0]        r_sw_sync;

    logic              w_is_periph;
    logic [15:0]       w_off;
    logic [RAM_AW-1:0] w_idx;
    logic              w_wr;
    logic [31:0]       w_timer;
    logic [31:0]       w_periph_rd;
    logic [31:0]       w_led_merged;

    assign w_is_periph  = (data_sram_addr[31:16] == PERIPH_HI);
    assign w_off        = data_sram_addr[15:0];
    assign w_idx        = data_sram_addr[RAM_AW+1:2];
    assign w_wr         = data_sram_en && (data_sram_wen != 4'b0000) && !rst;
    assign w_led_merged = byte_merge({16'h0000, r_led}, data_sram_wdata, {2'b00, data_sram_wen[1:0]});

    always_comb begin
        w_periph_rd = 32'h0;
        case (w_off)
            OFF_LED:    w_periph_rd = {16'h0000, r_led};
            OFF_NUM:    w_periph_rd = r_num;
            OFF_SWITCH: w_periph_rd = {24'h000000, r_sw_sync};
            OFF_TIMER:  w_periph_rd = w_timer;
            default:    w_periph_rd = 32'h0;
        endcase
    end

    // RAM is never reset; writes are suppressed while rst is high via w_wr.
    always_ff @(posedge clk) begin
        if (w_wr && !w_is_periph) begin
            for (int i = 0; i < 4; i++)
                if (data_sram_wen[i])
                    r_ram[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
    end

    // Read-first: rdata captures the pre-write contents on write cycles too.
    always_ff @(posedge clk) begin
        if (rst)
            r_rdata <= 32'h0;
        else if (data_sram_en)
            r_rdata <= w_is_periph ? w_periph_rd : r_ram[w_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led     <= 16'h0000;
            r_num     <= 32'h0;
            r_sw_meta <= 8'h00;
            r_sw_sync <= 8'h00;
        end else begin
            r_sw_meta <= switch_in;
            r_sw_sync <= r_sw_meta;
            if (w_wr && w_is_periph && w_off == OFF_LED)
                r_led <= w_led_merged[15:0];
            if (w_wr && w_is_periph && w_off == OFF_NUM)
                r_num <= byte_merge(r_num, data_sram_wdata, data_sram_wen);
        end
    end

`ifdef SRAM_RESP_TIMER_EN
    logic [31:0] r_timer;

    // A write replaces that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst)
            r_timer <= 32'h0;
        else if (w_wr && w_is_periph && w_off == OFF_TIMER)
            r_timer <= byte_merge(r_timer, data_sram_wdata, data_sram_wen);
        else
            r_timer <= r_timer + 32'd1;
    end

    assign w_timer = r_timer;
`else
    assign w_timer = 32'h0;
`endif

    assign data_sram_rdata = r_rdata;
    assign led             = r_led;
    assign num_data        = r_num;

endmodule

// File: tb/tb_data_sram_resp.sv
// tb/tb_data_sram_resp.sv - directed table-driven bench for data_sram_resp.
module tb_data_sram_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  sw;
    logic [15:0] led;
    logic [31:0] num;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    data_sram_resp #(.RAM_AW(10), .PERIPH_HI(16'h1faf)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .switch_in       (sw),
        .led             (led),
        .num_data        (num)
    );

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [15:0] exp_led;
        logic [31:0] exp_num;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en = e; wen = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'hf, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0,         16'h0000, 32'h0};
        vecs[1]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         1'b1, 32'h1234_5678, 16'h0000, 32'h0};
        vecs[2]  = '{1'b1, 4'h5, 32'h0000_0010, 32'hAABB_CCDD, 1'b1, 32'h1234_5678, 16'h0000, 32'h0};
        vecs[3]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         1'b1, 32'h12BB_56DD, 16'h0000, 32'h0};
        vecs[4]  = '{1'b0, 4'hf, 32'h0000_0010, 32'hFFFF_FFFF, 1'b1, 32'h12BB_56DD, 16'h0000, 32'h0};
        vecs[5]  = '{1'b1, 4'h0, 32'h1faf_f010, 32'h0,         1'b1, 32'h0,         16'h0000, 32'h0};
        vecs[6]  = '{1'b1, 4'hf, 32'h1faf_f000, 32'hffff_a5a5, 1'b1, 32'h0,         16'ha5a5, 32'h0};
        vecs[7]  = '{1'b1, 4'h0, 32'h1faf_f000, 32'h0,         1'b1, 32'h0000_a5a5, 16'ha5a5, 32'h0};
        vecs[8]  = '{1'b1, 4'h3, 32'h1faf_f010, 32'h1122_3344, 1'b1, 32'h0,         16'ha5a5, 32'h0000_3344};
        vecs[9]  = '{1'b1, 4'hc, 32'h1faf_f010, 32'h5566_7788, 1'b1, 32'h0000_3344, 16'ha5a5, 32'h5566_3344};
        vecs[10] = '{1'b1, 4'h0, 32'h1faf_f0ff, 32'h0,         1'b1, 32'h0,         16'ha5a5, 32'h5566_3344};
        vecs[11] = '{1'b1, 4'hf, 32'h1faf_f0ff, 32'hdead_beef, 1'b1, 32'h0,         16'ha5a5, 32'h5566_3344};
        vecs[12] = '{1'b1, 4'h0, 32'h0000_1010, 32'h0,         1'b1, 32'h12BB_56DD, 16'ha5a5, 32'h5566_3344};
        vecs[13] = '{1'b1, 4'hc, 32'h1faf_f000, 32'h1234_0000, 1'b1, 32'h0000_a5a5, 16'ha5a5, 32'h5566_3344};
        vecs[14] = '{1'b1, 4'h2, 32'h1faf_f000, 32'h0000_7700, 1'b1, 32'h0000_a5a5, 16'h77a5, 32'h5566_3344};
        vecs[15] = '{1'b1, 4'hf, 32'h1faf_f020, 32'hffff_ffff, 1'b1, 32'h0,         16'h77a5, 32'h5566_3344};
        vecs[16] = '{1'b1, 4'h0, 32'h1faf_f020, 32'h0,         1'b1, 32'h0,         16'h77a5, 32'h5566_3344};
        vecs[17] = '{1'b1, 4'h0, 32'h1fae_0010, 32'h0,         1'b1, 32'h12BB_56DD, 16'h77a5, 32'h5566_3344};

        rst = 1'b1; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0; sw = 8'h00;
        @(posedge clk); @(posedge clk); #1;
        check("reset_rdata", rdata, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0);
        check("reset_num", num, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
            check($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
            check($sformatf("vec%0d_num", i), num, vecs[i].exp_num);
        end

        // switch synchronizer latency
        sw = 8'h3c;
        step(1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b1, 4'h0, 32'h1faf_f020, 32'h0);
        check("switch_rd", rdata, 32'h0000_003c);

        // timer write priority and wrap
        step(1'b1, 4'hf, 32'h1faf_e000, 32'hffff_fffe);
        step(1'b1, 4'h0, 32'h1faf_e000, 32'h0);
`ifdef SRAM_RESP_TIMER_EN
        check("timer_rd0", rdata, 32'hffff_fffe);
`else
        check("timer_rd0", rdata, 32'h0);
`endif
        step(1'b1, 4'h0, 32'h1faf_e000, 32'h0);
`ifdef SRAM_RESP_TIMER_EN
        check("timer_rd1", rdata, 32'hffff_ffff);
`else
        check("timer_rd1", rdata, 32'h0);
`endif
        step(1'b1, 4'h0, 32'h1faf_e000, 32'h0);
        check("timer_wrap", rdata, 32'h0);

        // reset mid-stream with concurrent writes
        step(1'b1, 4'hf, 32'h0000_0020, 32'hcafe_f00d);
        rst = 1'b1;
        step(1'b1, 4'hf, 32'h1faf_f000, 32'h0000_beef);
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_num", num, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        step(1'b1, 4'hf, 32'h0000_0020, 32'hdead_beef);
        check("rst_rdata2", rdata, 32'h0);
        rst = 1'b0;
        step(1'b1, 4'h0, 32'h1faf_e000, 32'h0);
        check("rst_timer0", rdata, 32'h0);
        step(1'b1, 4'h0, 32'h1faf_e000, 32'h0);
`ifdef SRAM_RESP_TIMER_EN
        check("rst_timer1", rdata, 32'h1);
`else
        check("rst_timer1", rdata, 32'h0);
`endif
        step(1'b1, 4'h0, 32'h0000_0020, 32'h0);
        check("ram_keep", rdata, 32'hcafe_f00d);
        step(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        check("ram_keep2", rdata, 32'h12BB_56DD);
        step(1'b1, 4'h0, 32'h1faf_f000, 32'h0);
        check("led_after_rst", rdata, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
